csr_file: RTL and testbench

// Machine-mode CSR register file for the RV32I core. Services Zicsr accesses
// (read, write, set, clear) from the execute stage. Records synchronous traps

---
 rtl/csr_if.sv | 23 ++
 rtl/csr_file.sv | 123 ++++++++++++
 tb/tb_csr_file.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/csr_if.sv
// Execute-stage <-> CSR file bus: Zicsr access, trap report and handler address.
interface csr_if;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [1:0]  csr_op;
  logic [31:0] csr_rdata;
  logic        trap;
  logic [3:0]  trap_cause;
  logic [31:0] trap_value;
  logic [31:0] trap_pc;
  logic        trap_handled;
  logic [31:0] trap_target_pc;

  modport master (
    output csr_addr, csr_wdata, csr_op, trap, trap_cause, trap_value, trap_pc,
    input  csr_rdata, trap_handled, trap_target_pc
  );

  modport slave (
    input  csr_addr, csr_wdata, csr_op, trap, trap_cause, trap_value, trap_pc,
    output csr_rdata, trap_handled, trap_target_pc
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32I core: Zicsr read/write/set/clear,
// synchronous trap capture and a free-running 64-bit cycle counter.
module csr_file #(
  parameter logic [31:0] HART_ID    = 32'd0,
  parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
  input  logic   clk,
  input  logic   rst,
  csr_if.slave   bus
);

  typedef enum logic [1:0] {OP_NOP, OP_WRITE, OP_SET, OP_CLEAR} csr_op_e;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [31:0] MIE_MASK  = 32'h0000_0888;
  localparam logic [31:0] MEPC_MASK = 32'hFFFF_FFFC;

  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q;
  logic        trap_handled_q;

  logic [31:0] mstatus_rd, rdata, wval;
  logic [63:0] cycle_inc;
  logic        wen;
  csr_op_e     op;

  // MPP is hardwired to M-mode; only MIE/MPIE hold state
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign op         = csr_op_e'(bus.csr_op);

  always_comb begin
    rdata = '0;
    case (bus.csr_addr)
      A_MSTATUS:          rdata = mstatus_rd;
      A_MISA:             rdata = MISA_VALUE;
      A_MIE:              rdata = mie_q;
      A_MTVEC:            rdata = mtvec_q;
      A_MSCRATCH:         rdata = mscratch_q;
      A_MEPC:             rdata = mepc_q;
      A_MCAUSE:           rdata = mcause_q;
      A_MTVAL:            rdata = mtval_q;
      A_MCYCLE, A_CYCLE:  rdata = mcycle_q[31:0];
      A_MCYCLEH, A_CYCLEH: rdata = mcycle_q[63:32];
      A_MHARTID:          rdata = HART_ID;
      default:            rdata = '0;
    endcase
  end

  always_comb begin
    wval = rdata;
    case (op)
      OP_WRITE: wval = bus.csr_wdata;
      OP_SET:   wval = rdata | bus.csr_wdata;
      OP_CLEAR: wval = rdata & ~bus.csr_wdata;
      default:  wval = rdata;
    endcase
  end

  // A trap in the same cycle suppresses the whole CSR op
  assign wen       = (op != OP_NOP) && !bus.trap;
  assign cycle_inc = mcycle_q + 64'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie    <= 1'b0;
      mstatus_mpie   <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      trap_handled_q <= 1'b0;
    end else begin
      trap_handled_q <= bus.trap;
      // A write to one half replaces only that half; the other keeps the carry
      mcycle_q[31:0]  <= (wen && bus.csr_addr == A_MCYCLE)  ? wval : cycle_inc[31:0];
      mcycle_q[63:32] <= (wen && bus.csr_addr == A_MCYCLEH) ? wval : cycle_inc[63:32];
      if (bus.trap) begin
        mepc_q       <= bus.trap_pc & MEPC_MASK;
        mcause_q     <= {28'b0, bus.trap_cause};
        mtval_q      <= bus.trap_value;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (wen) begin
        case (bus.csr_addr)
          A_MSTATUS: begin
            mstatus_mie  <= wval[3];
            mstatus_mpie <= wval[7];
          end
          A_MIE:      mie_q      <= wval & MIE_MASK;
          A_MTVEC:    mtvec_q    <= wval;
          A_MSCRATCH: mscratch_q <= wval;
          A_MEPC:     mepc_q     <= wval & MEPC_MASK;
          A_MCAUSE:   mcause_q   <= wval;
          A_MTVAL:    mtval_q    <= wval;
          default:    ;
        endcase
      end
    end
  end

  assign bus.csr_rdata      = rdata;
  assign bus.trap_handled   = trap_handled_q;
  assign bus.trap_target_pc = {mtvec_q[31:2], 2'b00};

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file: reset values, Zicsr ops,
// trap capture/priority, masks and mcycle carry behaviour.
module tb_csr_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  csr_if bus();

  csr_file #(.HART_ID(32'd0), .MISA_VALUE(32'h4000_0100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    bus.csr_addr = addr;
    bus.csr_op   = 2'd0;
    #1;
    chk(tag, bus.csr_rdata, exp);
  endtask

  // Apply an op across one rising edge, then return to NOP
  task automatic op(input logic [11:0] addr, input logic [1:0] o, input logic [31:0] wd);
    bus.csr_addr  = addr;
    bus.csr_op    = o;
    bus.csr_wdata = wd;
    tick();
    bus.csr_op    = 2'd0;
  endtask

  task automatic take_trap(input logic [3:0] cause, input logic [31:0] val, input logic [31:0] pc);
    bus.trap       = 1'b1;
    bus.trap_cause = cause;
    bus.trap_value = val;
    bus.trap_pc    = pc;
    tick();
    bus.trap       = 1'b0;
  endtask

  initial begin
    bus.csr_addr   = '0;
    bus.csr_wdata  = '0;
    bus.csr_op     = 2'd0;
    bus.trap       = 1'b0;
    bus.trap_cause = '0;
    bus.trap_value = '0;
    bus.trap_pc    = '0;

    tick();
    tick();
    chk("handled_in_reset", {31'b0, bus.trap_handled}, 32'd0);
    rst = 1'b0;

    rd(12'h301, 32'h4000_0100, "misa_reset");
    rd(12'h300, 32'h0000_1800, "mstatus_reset");
    rd(12'h344, 32'h0,         "mip_reset");
    rd(12'hB00, 32'h0,         "mcycle_reset");
    rd(12'hF14, 32'h0,         "mhartid");
    rd(12'h305, 32'h0,         "mtvec_reset");

    // Five edges after reset release
    repeat (5) tick();
    rd(12'hB00, 32'd5, "mcycle_5");
    rd(12'hC00, 32'd5, "cycle_alias_5");
    rd(12'hB80, 32'd0, "mcycleh_5");

    // mtvec write / set / clear; rdata shows the old value during the op
    bus.csr_addr = 12'h305; bus.csr_op = 2'd1; bus.csr_wdata = 32'h10; #1;
    chk("mtvec_pre_update", bus.csr_rdata, 32'h0);
    tick(); bus.csr_op = 2'd0;
    rd(12'h305, 32'h10, "mtvec_write");
    op(12'h305, 2'd2, 32'h3);
    rd(12'h305, 32'h13, "mtvec_set");
    op(12'h305, 2'd3, 32'h2);
    rd(12'h305, 32'h11, "mtvec_clear");
    chk("trap_target_pc", bus.trap_target_pc, 32'h10);

    // Trap coincident with a mscratch write: trap wins
    bus.csr_addr = 12'h340; bus.csr_op = 2'd1; bus.csr_wdata = 32'h55;
    #1;
    chk("handled_before_trap", {31'b0, bus.trap_handled}, 32'd0);
    take_trap(4'd3, 32'hDEAD_BEEF, 32'h20);
    chk("handled_pulse", {31'b0, bus.trap_handled}, 32'd1);
    rd(12'h340, 32'h0,         "mscratch_suppressed");
    rd(12'h341, 32'h20,        "mepc_trap1");
    rd(12'h342, 32'h3,         "mcause_trap1");
    rd(12'h343, 32'hDEAD_BEEF, "mtval_trap1");
    rd(12'h300, 32'h0000_1800, "mstatus_trap1");
    tick();
    chk("handled_one_cycle", {31'b0, bus.trap_handled}, 32'd0);

    // MIE -> MPIE on trap; unaligned pc is truncated into mepc
    op(12'h300, 2'd2, 32'h8);
    rd(12'h300, 32'h0000_1808, "mstatus_set_mie");
    take_trap(4'd2, 32'h1, 32'h47);
    rd(12'h300, 32'h0000_1880, "mstatus_trap2");
    rd(12'h341, 32'h44,        "mepc_trap2_align");
    rd(12'h342, 32'h2,         "mcause_trap2");

    // Masks, read-only and unmapped addresses
    op(12'h340, 2'd1, 32'hA5A5_5A5A);
    rd(12'h340, 32'hA5A5_5A5A, "mscratch_write");
    op(12'h301, 2'd1, 32'h1234_5678);
    rd(12'h301, 32'h4000_0100, "misa_ro");
    op(12'h7C0, 2'd1, 32'h1234_5678);
    rd(12'h7C0, 32'h0,         "unmapped");
    op(12'h304, 2'd1, 32'hFFFF_FFFF);
    rd(12'h304, 32'h0000_0888, "mie_mask");
    op(12'h341, 2'd1, 32'h0000_0007);
    rd(12'h341, 32'h4,         "mepc_mask");
    op(12'h300, 2'd1, 32'hFFFF_FFFF);
    rd(12'h300, 32'h0000_1888, "mstatus_mask");
    op(12'h344, 2'd1, 32'hFFFF_FFFF);
    rd(12'h344, 32'h0,         "mip_ro");

    // mcycle low-half write then carry into the high half
    op(12'hB00, 2'd1, 32'hFFFF_FFFF);
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_written");
    rd(12'hB80, 32'h0,         "mcycleh_before_carry");
    tick();
    rd(12'hB00, 32'h0, "mcycle_wrap");
    rd(12'hB80, 32'h1, "mcycleh_carry");
    rd(12'hC80, 32'h1, "cycleh_alias");
    op(12'hB80, 2'd1, 32'h5);
    rd(12'hB80, 32'h5, "mcycleh_write");
    rd(12'hB00, 32'h1, "mcycle_keeps_counting");
    op(12'hC00, 2'd1, 32'h0);
    rd(12'hC00, 32'h2, "cycle_ro");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
